// File: rtl/ysyx_23060203_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one IMEM fetch at a time and hands the
// returned word to IDU. Optional misaligned-redirect fault path: FETCH_MISALIGN_CHECK_EN.
module ysyx_23060203_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_err,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc
);

  localparam logic [1:0] REQ   = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic [1:0] FAULT = 2'd3;
`endif

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        inst_err_q, inst_err_d;
  // Keeps the request low on the release cycle so the first fetch appears one cycle later.
  logic        active_q;
  logic [31:0] target;
  logic        unused_rpc_bits;

  assign target          = {redirect_pc[31:2], 2'b00};
  assign unused_rpc_bits = ^redirect_pc[1:0];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    inst_err_d = inst_err_q;
    case (state_q)
      REQ: begin
        if (active_q && imem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (imem_resp_valid) begin
          inst_d     = imem_resp_data;
          inst_err_d = imem_resp_err;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (inst_ready) begin
          state_d = REQ;
          pc_d    = redirect_valid ? target : pc_q + 32'd4;
`ifdef FETCH_MISALIGN_CHECK_EN
          if (redirect_valid && redirect_pc[1]) begin
            pc_d       = {redirect_pc[31:1], 1'b0};
            inst_d     = 32'h0;
            inst_err_d = 1'b1;
            state_d    = FAULT;
          end
`endif
        end
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      FAULT: begin
        // Only an EXU redirect can leave the fault; a plain handshake re-presents it.
        if (inst_ready && redirect_valid) begin
          if (redirect_pc[1]) begin
            pc_d = {redirect_pc[31:1], 1'b0};
          end else begin
            pc_d    = target;
            state_d = REQ;
          end
        end
      end
`endif
      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= REQ;
      pc_q       <= RESET_PC;
      inst_q     <= 32'h0;
      inst_err_q <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      inst_err_q <= inst_err_d;
      active_q   <= 1'b1;
    end
  end

  assign imem_req_valid = active_q && (state_q == REQ);
  assign imem_req_addr  = pc_q;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign inst_valid     = (state_q == HOLD) || (state_q == FAULT);
`else
  assign inst_valid     = (state_q == HOLD);
`endif
  assign inst           = inst_q;
  assign inst_err       = inst_err_q;
  assign inst_pc        = pc_q;
  assign pc             = pc_q;

endmodule
